// File: rtl/qsys_audio_pkg.sv
// Shared types and constants for the soundtrack playback path.
package qsys_audio_pkg;

  localparam int SAMPLE_W          = 16;
  localparam int DEFAULT_NUM_WORDS = 732636;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/qsys_sample_fifo.sv
// Small synchronous show-ahead FIFO used to prefetch PCM samples.
module qsys_sample_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/qsys_soundtrack_reader.sv
// Avalon-MM read master that prefetches PCM samples from the soundtrack ROM
// and hands exactly one sample to the codec on every sample_tick.
module qsys_soundtrack_reader
  import qsys_audio_pkg::*;
#(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = SAMPLE_W,
  parameter int NUM_WORDS  = DEFAULT_NUM_WORDS,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_read,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              play,
  input  logic              loop_en,
  input  logic              sample_tick,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  output logic              underrun,
  output logic              done,
  output logic              playing
);
  localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam int                OCC_W     = CNT_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
  localparam logic [OCC_W-1:0]  DEPTH_LIM = OCC_W'(FIFO_DEPTH);

  state_e            state;
  state_e            state_nxt;
  logic [ADDR_W-1:0] addr_cnt;
  logic              end_reached;
  logic              inflight;
  logic              read_issue;
  logic [CNT_W-1:0]  fifo_count;
  logic [OCC_W-1:0]  occupancy;
  logic              fifo_empty;
  logic              fifo_full;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_clear;
  logic [DATA_W-1:0] fifo_dout;

  // Entries already stored plus the one word still on the bus must fit.
  assign occupancy  = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight};
  assign read_issue = (state == ST_PLAY) && !end_reached && !fifo_full &&
                      (occupancy < DEPTH_LIM);

  assign avm_read       = read_issue;
  assign avm_chipselect = read_issue;
  assign avm_address    = addr_cnt;
  assign done           = (state == ST_DONE);
  assign playing        = (state == ST_PLAY);

  assign fifo_push  = inflight && (state == ST_PLAY);
  assign fifo_pop   = sample_tick && (state == ST_PLAY) && !fifo_empty;
  assign fifo_clear = (state == ST_FLUSH);

  qsys_sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .clear   (fifo_clear),
    .din     (avm_readdata),
    .dout    (fifo_dout),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (play) state_nxt = ST_PLAY;
      ST_PLAY: begin
        if (!play)                                       state_nxt = ST_FLUSH;
        else if (end_reached && fifo_empty && !inflight) state_nxt = ST_DONE;
      end
      ST_FLUSH: if (!inflight) state_nxt = ST_IDLE;
      ST_DONE:  if (!play) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Request stage: state, address counter and the one-deep in-flight flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      addr_cnt    <= '0;
      end_reached <= 1'b0;
      inflight    <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= read_issue;
      if ((state == ST_IDLE) && play) begin
        addr_cnt    <= '0;
        end_reached <= 1'b0;
      end else if (read_issue) begin
        if (addr_cnt == LAST_ADDR) begin
          if (loop_en) addr_cnt    <= '0;
          else         end_reached <= 1'b1;
        end else begin
          addr_cnt <= addr_cnt + ADDR_W'(1);
        end
      end
    end
  end

  // Codec stage: one registered sample per tick, muted when nothing is ready.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_out   <= '0;
      sample_valid <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      underrun     <= 1'b0;
      if (sample_tick) begin
        if (fifo_pop) begin
          sample_out   <= fifo_dout;
          sample_valid <= 1'b1;
        end else begin
          sample_out <= '0;
          underrun   <= (state == ST_PLAY);
        end
      end
    end
  end

endmodule

// File: tb/tb_qsys_soundtrack_reader.sv
// Bench for qsys_soundtrack_reader with an 8-word track and a latency-1 ROM.
module tb_qsys_soundtrack_reader;
  localparam int TB_WORDS = 8;
  localparam int DEPTH    = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        play;
  logic        loop_en;
  logic        sample_tick;
  logic [19:0] avm_address;
  logic        avm_chipselect;
  logic        avm_read;
  logic [15:0] avm_readdata;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        underrun;
  logic        done;
  logic        playing;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] rom [TB_WORDS];

  always #5 clk = ~clk;

  qsys_soundtrack_reader #(
    .ADDR_W     (20),
    .DATA_W     (16),
    .NUM_WORDS  (TB_WORDS),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_read       (avm_read),
    .avm_readdata   (avm_readdata),
    .play           (play),
    .loop_en        (loop_en),
    .sample_tick    (sample_tick),
    .sample_out     (sample_out),
    .sample_valid   (sample_valid),
    .underrun       (underrun),
    .done           (done),
    .playing        (playing)
  );

  // ROM slave: data one cycle after a read, junk on the bus otherwise.
  always @(posedge clk)
    avm_readdata <= avm_read ? rom[int'(avm_address) % TB_WORDS] : 16'($urandom);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: player mode, prefetch queue, read pointer, pending bus word.
  typedef enum int {M_IDLE, M_PLAY, M_FLUSH, M_DONE} mmode_e;
  mmode_e      m_mode = M_IDLE;
  int          m_cnt = 0;
  bit          m_end = 1'b0;
  bit          m_infl = 1'b0;
  logic [15:0] m_infl_d = '0;
  logic [15:0] m_sample = '0;
  bit          m_valid = 1'b0;
  bit          m_under = 1'b0;
  logic [15:0] m_q[$];

  function automatic bit m_read();
    return (m_mode == M_PLAY) && !m_end && ((m_q.size() + int'(m_infl)) < DEPTH);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_mode = M_IDLE; m_cnt = 0; m_end = 1'b0; m_infl = 1'b0;
      m_infl_d = '0; m_sample = '0; m_valid = 1'b0; m_under = 1'b0;
      m_q.delete();
    end else begin : step
      bit     iss;
      int     iss_addr;
      mmode_e nm;
      iss      = m_read();
      iss_addr = m_cnt;
      nm       = m_mode;
      case (m_mode)
        M_IDLE:  if (play) nm = M_PLAY;
        M_PLAY: begin
          if (!play) nm = M_FLUSH;
          else if (m_end && m_q.size() == 0 && !m_infl) nm = M_DONE;
        end
        M_FLUSH: if (!m_infl) nm = M_IDLE;
        M_DONE:  if (!play) nm = M_IDLE;
        default: nm = M_IDLE;
      endcase
      m_valid = 1'b0;
      m_under = 1'b0;
      if (sample_tick) begin
        if (m_mode == M_PLAY && m_q.size() > 0) begin
          m_sample = m_q.pop_front();
          m_valid  = 1'b1;
        end else begin
          m_sample = '0;
          m_under  = (m_mode == M_PLAY);
        end
      end
      if (m_infl && m_mode == M_PLAY) m_q.push_back(m_infl_d);
      if (m_mode == M_FLUSH) m_q.delete();
      if (m_mode == M_IDLE && play) begin
        m_cnt = 0;
        m_end = 1'b0;
      end else if (iss) begin
        if (m_cnt == TB_WORDS - 1) begin
          if (loop_en) m_cnt = 0;
          else         m_end = 1'b1;
        end else begin
          m_cnt++;
        end
      end
      m_infl   = iss;
      m_infl_d = rom[iss_addr];
      m_mode   = nm;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("avm_read",       avm_read,       m_read());
      chk("avm_chipselect", avm_chipselect, m_read());
      chk("avm_address",    avm_address,    m_cnt);
      chk("sample_out",     sample_out,     m_sample);
      chk("sample_valid",   sample_valid,   m_valid);
      chk("underrun",       underrun,       m_under);
      chk("done",           done,           m_mode == M_DONE);
      chk("playing",        playing,        m_mode == M_PLAY);
      chk("fifo_count",     dut.u_fifo.count, m_q.size());
      chk("fifo_overflow",  dut.u_fifo.push && dut.u_fifo.full && !dut.u_fifo.pop, 0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic tick_once();
    cyc();
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
  endtask

  task automatic stop_play();
    cyc();
    play = 1'b0;
    repeat (3) cyc();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, n_checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          n_valid;
    logic [15:0] last;
    bit          seen;
    bit          wrap_ok;
    logic [19:0] addrs[$];
    logic [15:0] samps[$];

    for (int i = 0; i < TB_WORDS; i++) rom[i] = 16'h0100 + 16'(i);
    reset_n = 1'b0; play = 1'b1; loop_en = 1'b1; sample_tick = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_avm_read",     avm_read,       0);
    chk("rst_chipselect",   avm_chipselect, 0);
    chk("rst_address",      avm_address,    0);
    chk("rst_sample_out",   sample_out,     0);
    chk("rst_sample_valid", sample_valid,   0);
    chk("rst_underrun",     underrun,       0);
    chk("rst_done",         done,           0);
    chk("rst_playing",      playing,        0);
    chk("rst_fifo_count",   dut.u_fifo.count, 0);
    cyc();
    reset_n = 1'b1;

    // Back-to-back reads 0..3, then stall with the prefetch budget used up.
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t1_read", avm_read, k < 4);
      if (k < 4) chk("t1_addr", avm_address, k);
    end

    // Sparse ticks: samples arrive in address order.
    for (int t = 0; t < 12; t++) begin
      tick_once();
      @(negedge clk);
      if (t < 2) begin
        chk("t2_valid",  sample_valid, 1);
        chk("t2_sample", sample_out, 16'h0100 + t);
      end
      repeat (6) @(posedge clk);
    end

    // Drop play with 3 words queued and one on the bus.
    stop_play();
    play = 1'b1;
    cyc();
    repeat (4) cyc();
    @(negedge clk);
    chk("t6_count3", dut.u_fifo.count, 3);
    chk("t6_stall",  avm_read, 0);
    #1 play = 1'b0;
    @(negedge clk);
    chk("t6_flush_playing", playing,  0);
    chk("t6_flush_read",    avm_read, 0);
    @(negedge clk);
    chk("t6_idle_count",   dut.u_fifo.count, 0);
    chk("t6_idle_playing", playing, 0);
    #1 play = 1'b1;
    @(negedge clk);
    chk("t6_restart_read", avm_read,    1);
    chk("t6_restart_addr", avm_address, 0);

    // Tick on the very first PLAY cycle.
    stop_play();
    play = 1'b1;
    cyc();
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    @(negedge clk);
    chk("t5_underrun", underrun,     1);
    chk("t5_mute",     sample_out,   0);
    chk("t5_novalid",  sample_valid, 0);
    tick_once();
    @(negedge clk);
    chk("t5_next_valid",  sample_valid, 1);
    chk("t5_next_sample", sample_out,   16'h0100);

    // End of track without looping.
    stop_play();
    loop_en = 1'b0;
    play    = 1'b1;
    n_valid = 0; last = '0; seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      cyc();
      sample_tick = (i % 3 == 0);
      @(negedge clk);
      if (sample_valid) begin
        n_valid++;
        last = sample_out;
      end
      if (done) seen = 1'b1;
    end
    sample_tick = 1'b0;
    chk("t3_done_seen", seen,    1);
    chk("t3_n_valid",   n_valid, 8);
    chk("t3_last",      last,    16'h0107);
    tick_once();
    @(negedge clk);
    chk("t3_after_mute",     sample_out,   0);
    chk("t3_after_underrun", underrun,     0);
    chk("t3_after_valid",    sample_valid, 0);
    chk("t3_after_done",     done,         1);

    // Looping track: address and sample streams wrap to 0.
    stop_play();
    loop_en = 1'b1;
    play    = 1'b1;
    for (int i = 0; i < 60; i++) begin
      cyc();
      sample_tick = (i % 2 == 0);
      @(negedge clk);
      if (avm_read)     addrs.push_back(avm_address);
      if (sample_valid) samps.push_back(sample_out);
    end
    sample_tick = 1'b0;
    chk("t4_nreads", addrs.size() >= 10, 1);
    for (int i = 0; i < 10; i++) chk("t4_addr", addrs[i], i % 8);
    wrap_ok = 1'b0;
    for (int j = 0; j + 1 < samps.size(); j++)
      if (samps[j] == 16'h0107 && samps[j+1] == 16'h0100) wrap_ok = 1'b1;
    chk("t4_wrap_7_to_0", wrap_ok, 1);

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      cyc();
      sample_tick = ($urandom_range(3) == 0);
      if (play ? ($urandom_range(63) == 0) : ($urandom_range(15) == 0)) play = ~play;
      if ($urandom_range(49) == 0) loop_en = ~loop_en;
      if ($urandom_range(999) == 0) begin
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
